// File: rtl/rv_ctrl_pkg.sv
// Shared opcode, ALU-code and control-bundle definitions for the RV32 decode/issue stage.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_MUL  = 5'd10;
  localparam logic [4:0] ALU_BEQ  = 5'd26;
  localparam logic [4:0] ALU_BNE  = 5'd27;
  localparam logic [4:0] ALU_BLT  = 5'd28;
  localparam logic [4:0] ALU_BGE  = 5'd29;
  localparam logic [4:0] ALU_BLTU = 5'd30;
  localparam logic [4:0] ALU_BGEU = 5'd31;

  typedef enum logic [1:0] {
    WDS_ALU = 2'd0,
    WDS_MEM = 2'd1,
    WDS_PC4 = 2'd2
  } wds_e;

  typedef enum logic [1:0] {
    ASRC_RS1  = 2'd0,
    ASRC_ZERO = 2'd1,
    ASRC_PC   = 2'd2
  } asrc_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Everything that travels down the ID/EX register.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       pc_jump_src;
    logic       do_branch;
    wds_e       wds;
    logic [2:0] sl_sel;
    asrc_e      lui_auipc_sel;
    logic [4:0] alu_ctrl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ex_lanes_t;

  typedef struct packed {
    ex_lanes_t lanes;
    logic      is_mul;
    logic      is_div;
  } ctrl_bundle_t;

  localparam ex_lanes_t    LANES_BUBBLE = '0;
  localparam ctrl_bundle_t CTRL_BUBBLE  = '0;

  // funct3 -> ALU op for the funct7=0 register/immediate forms.
  function automatic logic [4:0] alu_base_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational RV32I(+M) decoder: instruction word to control bundle and register-use flags.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0]  instr_i,
  output ctrl_bundle_t ctrl_o,
  output logic         uses_rs1_o,
  output logic         uses_rs2_o
);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  ctrl_bundle_t dec;
  logic         illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    dec           = CTRL_BUBBLE;
    dec.lanes.rd  = instr_i[11:7];
    dec.lanes.rs1 = instr_i[19:15];
    dec.lanes.rs2 = instr_i[24:20];
    illegal       = 1'b0;
    uses_rs1_o    = 1'b0;
    uses_rs2_o    = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs1_o          = 1'b1;
        uses_rs2_o          = 1'b1;
        dec.lanes.reg_write = 1'b1;
        case (funct7)
          F7_BASE: dec.lanes.alu_ctrl = alu_base_op(funct3);
          F7_ALT: begin
            if (funct3 == 3'b000)      dec.lanes.alu_ctrl = ALU_SUB;
            else if (funct3 == 3'b101) dec.lanes.alu_ctrl = ALU_SRA;
            else                       illegal = 1'b1;
          end
          F7_MULDIV: begin
            if (ENABLE_M) begin
              dec.lanes.alu_ctrl = ALU_MUL + {2'b00, funct3};
              dec.is_mul         = ~funct3[2];
              dec.is_div         = funct3[2];
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        uses_rs1_o          = 1'b1;
        dec.lanes.reg_write = 1'b1;
        dec.lanes.alu_src   = 1'b1;
        dec.lanes.alu_ctrl  = alu_base_op(funct3);
        // Shift immediates reuse funct7 as an opcode extension; everything else is immediate bits.
        if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)       dec.lanes.alu_ctrl = ALU_SRA;
          else if (funct7 != F7_BASE) illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        uses_rs1_o          = 1'b1;
        dec.lanes.reg_write = 1'b1;
        dec.lanes.wds       = WDS_MEM;
        dec.lanes.mem_read  = 1'b1;
        dec.lanes.alu_src   = 1'b1;
        dec.lanes.sl_sel    = funct3;
      end
      OPC_STORE: begin
        uses_rs1_o          = 1'b1;
        uses_rs2_o          = 1'b1;
        dec.lanes.mem_write = 1'b1;
        dec.lanes.alu_src   = 1'b1;
        dec.lanes.sl_sel    = funct3;
      end
      OPC_BRANCH: begin
        uses_rs1_o          = 1'b1;
        uses_rs2_o          = 1'b1;
        dec.lanes.do_branch = 1'b1;
        case (funct3)
          3'b000:  dec.lanes.alu_ctrl = ALU_BEQ;
          3'b001:  dec.lanes.alu_ctrl = ALU_BNE;
          3'b100:  dec.lanes.alu_ctrl = ALU_BLT;
          3'b101:  dec.lanes.alu_ctrl = ALU_BGE;
          3'b110:  dec.lanes.alu_ctrl = ALU_BLTU;
          3'b111:  dec.lanes.alu_ctrl = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.lanes.reg_write = 1'b1;
        dec.lanes.wds       = WDS_PC4;
      end
      OPC_JALR: begin
        uses_rs1_o            = 1'b1;
        dec.lanes.reg_write   = 1'b1;
        dec.lanes.wds         = WDS_PC4;
        dec.lanes.pc_jump_src = 1'b1;
      end
      OPC_LUI: begin
        dec.lanes.reg_write     = 1'b1;
        dec.lanes.alu_src       = 1'b1;
        dec.lanes.lui_auipc_sel = ASRC_ZERO;
      end
      OPC_AUIPC: begin
        dec.lanes.reg_write     = 1'b1;
        dec.lanes.alu_src       = 1'b1;
        dec.lanes.lui_auipc_sel = ASRC_PC;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Illegal encodings keep their register fields but drive no lanes and never start an M sequence.
  always_comb begin
    ctrl_o = dec;
    if (illegal) begin
      ctrl_o               = CTRL_BUBBLE;
      ctrl_o.lanes.rd      = dec.lanes.rd;
      ctrl_o.lanes.rs1     = dec.lanes.rs1;
      ctrl_o.lanes.rs2     = dec.lanes.rs2;
      ctrl_o.lanes.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID-stage control: decode, load-use bubble insertion, multi-cycle MUL/DIV hold and the ID/EX control register.
module id_ex_ctrl_stage
  import rv_ctrl_pkg::*;
#(
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MUL_CYCLES = 1,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instruction,
  input  logic        IdValid,
  input  logic        Flush,
  output logic        StallID,
  output logic        ExHold,
  output logic        ExValid,
  output logic        ExRegWrite,
  output logic        ExMemWrite,
  output logic        ExMemRead,
  output logic        ExALUSrc,
  output logic        ExPCJumpSrc,
  output logic        ExDoBranch,
  output logic [1:0]  ExWriteDataSrc,
  output logic [2:0]  ExStoreLoadSel,
  output logic [1:0]  ExLuiAuipcSel,
  output logic [4:0]  ExALUCtrl,
  output logic [4:0]  ExRd,
  output logic [4:0]  ExRs1,
  output logic [4:0]  ExRs2,
  output logic        ExIllegal
);

  localparam logic [5:0] MUL_INIT  = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_INIT  = 6'(DIV_CYCLES - 1);
  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
  localparam bit         DIV_MULTI = (DIV_CYCLES > 1);

  ctrl_bundle_t id_ctrl;
  logic         id_uses_rs1;
  logic         id_uses_rs2;

  state_e       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  ex_lanes_t    ex_q, ex_d;
  logic         ex_valid_q, ex_valid_d;

  logic         load_use;
  logic         issue;
  logic         multi_cycle;

  rv_ctrl_decode #(
    .ENABLE_M(ENABLE_M)
  ) u_decode (
    .instr_i   (Instruction),
    .ctrl_o    (id_ctrl),
    .uses_rs1_o(id_uses_rs1),
    .uses_rs2_o(id_uses_rs2)
  );

  assign load_use = ex_valid_q && ex_q.mem_read && (ex_q.rd != 5'd0) && IdValid &&
                    ((id_uses_rs1 && (id_ctrl.lanes.rs1 == ex_q.rd)) ||
                     (id_uses_rs2 && (id_ctrl.lanes.rs2 == ex_q.rd)));

  assign issue       = (state_q == ST_IDLE) && !Flush && !load_use && IdValid;
  assign multi_cycle = (id_ctrl.is_mul && MUL_MULTI) || (id_ctrl.is_div && DIV_MULTI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 6'd0;
      ex_q       <= LANES_BUBBLE;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    case (state_q)
      ST_IDLE: begin
        ex_d       = LANES_BUBBLE;
        ex_valid_d = 1'b0;
        if (issue) begin
          ex_d       = id_ctrl.lanes;
          ex_valid_d = 1'b1;
          if (multi_cycle) begin
            state_d = ST_BUSY;
            cnt_d   = id_ctrl.is_div ? DIV_INIT : MUL_INIT;
          end
        end
      end
      ST_BUSY: begin
        // ID/EX holds; the op leaves EX one cycle after the counter reaches 1.
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    StallID = 1'b0;
    ExHold  = 1'b0;
    case (state_q)
      ST_IDLE: StallID = !Flush && load_use;
      ST_BUSY: begin
        StallID = 1'b1;
        ExHold  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ExValid        = ex_valid_q;
  assign ExRegWrite     = ex_q.reg_write;
  assign ExMemWrite     = ex_q.mem_write;
  assign ExMemRead      = ex_q.mem_read;
  assign ExALUSrc       = ex_q.alu_src;
  assign ExPCJumpSrc    = ex_q.pc_jump_src;
  assign ExDoBranch     = ex_q.do_branch;
  assign ExWriteDataSrc = ex_q.wds;
  assign ExStoreLoadSel = ex_q.sl_sel;
  assign ExLuiAuipcSel  = ex_q.lui_auipc_sel;
  assign ExALUCtrl      = ex_q.alu_ctrl;
  assign ExRd           = ex_q.rd;
  assign ExRs1          = ex_q.rs1;
  assign ExRs2          = ex_q.rs2;
  assign ExIllegal      = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Bench for id_ex_ctrl_stage: two instances (M enabled with 4-cycle divide, M disabled) against an instruction-level model.
module tb_id_ex_ctrl_stage;

  typedef struct packed {
    logic       valid, regw, memw, memr, alusrc, pcj, dob;
    logic [1:0] wds;
    logic [2:0] sls;
    logic [1:0] lui;
    logic [4:0] alu;
    logic [4:0] rd, rs1, rs2;
    logic       ill;
  } ex_t;

  localparam int LM_A = 1;
  localparam int LD_A = 4;

  localparam logic [31:0] LW5     = 32'h0000A283; // lw  x5,0(x1)
  localparam logic [31:0] LW0     = 32'h0000A003; // lw  x0,0(x1)
  localparam logic [31:0] ADD_DEP = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] ADD_X0  = 32'h00200333; // add x6,x0,x2
  localparam logic [31:0] ADD_IND = 32'h00218333; // add x6,x3,x2
  localparam logic [31:0] DIV     = 32'h025241B3; // div x3,x4,x5
  localparam logic [31:0] BGEU    = 32'h0020F063; // bgeu x1,x2,0

  logic        clk, rst_n, id_valid, flush, chk_en;
  logic [31:0] instr;
  int          checks, errors;

  logic a_stall, a_hold, a_valid, a_regw, a_memw, a_memr, a_alusrc, a_pcj, a_dob, a_ill;
  logic [1:0] a_wds, a_lui;
  logic [2:0] a_sls;
  logic [4:0] a_alu, a_rd, a_rs1, a_rs2;
  logic b_stall, b_hold, b_valid, b_regw, b_memw, b_memr, b_alusrc, b_pcj, b_dob, b_ill;
  logic [1:0] b_wds, b_lui;
  logic [2:0] b_sls;
  logic [4:0] b_alu, b_rd, b_rs1, b_rs2;
  ex_t obs_a, obs_b;

  assign obs_a = {a_valid, a_regw, a_memw, a_memr, a_alusrc, a_pcj, a_dob, a_wds, a_sls, a_lui,
                  a_alu, a_rd, a_rs1, a_rs2, a_ill};
  assign obs_b = {b_valid, b_regw, b_memw, b_memr, b_alusrc, b_pcj, b_dob, b_wds, b_sls, b_lui,
                  b_alu, b_rd, b_rs1, b_rs2, b_ill};

  id_ex_ctrl_stage #(.ENABLE_M(1'b1), .MUL_CYCLES(LM_A), .DIV_CYCLES(LD_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .Instruction(instr), .IdValid(id_valid), .Flush(flush),
    .StallID(a_stall), .ExHold(a_hold), .ExValid(a_valid), .ExRegWrite(a_regw),
    .ExMemWrite(a_memw), .ExMemRead(a_memr), .ExALUSrc(a_alusrc), .ExPCJumpSrc(a_pcj),
    .ExDoBranch(a_dob), .ExWriteDataSrc(a_wds), .ExStoreLoadSel(a_sls), .ExLuiAuipcSel(a_lui),
    .ExALUCtrl(a_alu), .ExRd(a_rd), .ExRs1(a_rs1), .ExRs2(a_rs2), .ExIllegal(a_ill));

  id_ex_ctrl_stage #(.ENABLE_M(1'b0), .MUL_CYCLES(2), .DIV_CYCLES(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .Instruction(instr), .IdValid(id_valid), .Flush(flush),
    .StallID(b_stall), .ExHold(b_hold), .ExValid(b_valid), .ExRegWrite(b_regw),
    .ExMemWrite(b_memw), .ExMemRead(b_memr), .ExALUSrc(b_alusrc), .ExPCJumpSrc(b_pcj),
    .ExDoBranch(b_dob), .ExWriteDataSrc(b_wds), .ExStoreLoadSel(b_sls), .ExLuiAuipcSel(b_lui),
    .ExALUCtrl(b_alu), .ExRd(b_rd), .ExRs1(b_rs1), .ExRs2(b_rs2), .ExIllegal(b_ill));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  ex_t exp_a, exp_b;
  int  hold_a, hold_b;

  // Instruction-level meaning of an encoding; cls: 0 single-cycle, 1 multiply, 2 divide/remainder.
  function automatic ex_t mdec(input logic [31:0] ins, input bit en_m,
                               output bit u1, output bit u2, output int cls);
    ex_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit bad;
    int base;
    e = '0; u1 = 0; u2 = 0; cls = 0; bad = 0;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    base = int'(f3) + ((f3 != 0) ? 1 : 0) + ((f3 >= 6) ? 1 : 0);
    e.valid = 1'b1; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    case (op)
      7'h33: begin
        u1 = 1; u2 = 1; e.regw = 1;
        if (f7 == 7'h00) e.alu = 5'(base);
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'd7;
        else if (f7 == 7'h01 && en_m) begin e.alu = 5'(10 + int'(f3)); cls = (f3 < 4) ? 1 : 2; end
        else bad = 1;
      end
      7'h13: begin
        u1 = 1; e.regw = 1; e.alusrc = 1; e.alu = 5'(base);
        if (f3 == 3'd1 && f7 != 7'h00) bad = 1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) e.alu = 5'd7;
          else if (f7 != 7'h00) bad = 1;
        end
      end
      7'h03: begin u1 = 1; e.regw = 1; e.wds = 2'd1; e.memr = 1; e.alusrc = 1; e.sls = f3; end
      7'h23: begin u1 = 1; u2 = 1; e.memw = 1; e.alusrc = 1; e.sls = f3; end
      7'h63: begin
        u1 = 1; u2 = 1; e.dob = 1;
        if (f3 == 3'd2 || f3 == 3'd3) bad = 1;
        else e.alu = 5'(26 + ((f3 < 2) ? int'(f3) : int'(f3) - 2));
      end
      7'h6F: begin e.regw = 1; e.wds = 2'd2; end
      7'h67: begin u1 = 1; e.regw = 1; e.wds = 2'd2; e.pcj = 1; end
      7'h37: begin e.regw = 1; e.alusrc = 1; e.lui = 2'd1; end
      7'h17: begin e.regw = 1; e.alusrc = 1; e.lui = 2'd2; end
      default: bad = 1;
    endcase
    if (bad) begin
      e = '0; e.valid = 1'b1; e.ill = 1'b1; cls = 0;
      e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    end
    return e;
  endfunction

  function automatic bit lu(input ex_t e, input bit en_m);
    bit u1, u2;
    int c;
    void'(mdec(instr, en_m, u1, u2, c));
    return e.valid && e.memr && (e.rd != 5'd0) && id_valid &&
           ((u1 && instr[19:15] == e.rd) || (u2 && instr[24:20] == e.rd));
  endfunction

  task automatic mstep(inout ex_t e, inout int hold, input bit en_m, input int lm, input int ld);
    bit u1, u2;
    int cls, lat;
    if (hold > 0) begin
      hold--;
    end else if (flush || lu(e, en_m) || !id_valid) begin
      e = '0;
    end else begin
      e = mdec(instr, en_m, u1, u2, cls);
      lat = (cls == 1) ? lm : (cls == 2) ? ld : 1;
      if (lat > 1) hold = lat - 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic cmp(input string nm, input ex_t act, input ex_t ex, input logic ah, input logic eh,
                     input logic as, input logic es);
    checks += 3;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s bundle t=%0t got %h want %h", nm, $time, act, ex);
    end
    if (ah !== eh) begin
      errors++;
      $display("FAIL %s ExHold t=%0t got %b want %b", nm, $time, ah, eh);
    end
    if (as !== es) begin
      errors++;
      $display("FAIL %s StallID t=%0t got %b want %b", nm, $time, as, es);
    end
  endtask

  task automatic chk(input string nm, input int act, input int ex);
    checks++;
    if (act != ex) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, ex);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("dut_a", obs_a, exp_a, a_hold, hold_a > 0, a_stall, (hold_a > 0) || (!flush && lu(exp_a, 1'b1)));
      cmp("dut_b", obs_b, exp_b, b_hold, hold_b > 0, b_stall, (hold_b > 0) || (!flush && lu(exp_b, 1'b0)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] i, input logic v, input logic f);
    instr = i; id_valid = v; flush = f;
    @(negedge clk);
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    if (rst_n) begin
      mstep(exp_a, hold_a, 1'b1, LM_A, LD_A);
      mstep(exp_b, hold_b, 1'b0, 2, 32);
    end
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] r;
    rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7)); f7 = 7'($urandom); r = $urandom;
    case ($urandom_range(0, 11))
      0:  return {7'h00, rs2, rs1, f3, rd, 7'h33};
      1:  return {7'h20, rs2, rs1, f3, rd, 7'h33};
      2:  return {7'h01, rs2, rs1, f3, rd, 7'h33};
      3:  return {f7, rs2, rs1, f3, rd, 7'h13};
      4:  return {($urandom_range(0, 2) == 0) ? 7'h00 : ($urandom_range(0, 1) == 0) ? 7'h20 : f7,
                  rs2, rs1, ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5, rd, 7'h13};
      5:  return {r[31:20], rs1, f3, rd, 7'h03};
      6:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'h23};
      7:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'h63};
      8:  return {r[31:12], rd, 7'h6F};
      9:  return {r[31:20], rs1, f3, rd, 7'h67};
      10: return {r[31:12], rd, ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17};
      default: return r;
    endcase
  endfunction

  initial begin
    int v, h, s;
    bit keep;
    checks = 0; errors = 0; chk_en = 1'b0;
    rst_n = 1'b0; instr = '0; id_valid = 1'b0; flush = 1'b0;
    exp_a = '0; exp_b = '0; hold_a = 0; hold_b = 0;
    #12;
    chk("rst_bundle_a", $countones(obs_a), 0);
    chk("rst_hold_a", int'(a_hold), 0);
    chk("rst_stall_a", int'(a_stall), 0);
    chk("rst_bundle_b", $countones(obs_b), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // load-use: one stall, one bubble, then the dependent add issues
    drive(LW5, 1, 0);      chk("lw_nostall", int'(a_stall), 0);   tick;
    drive(ADD_DEP, 1, 0);  chk("lu_stall", int'(a_stall), 1);     chk("lu_memread", int'(a_memr), 1); tick;
    drive(ADD_DEP, 1, 0);  chk("lu_bubble", int'(a_valid), 0);    chk("lu_one_stall", int'(a_stall), 0); tick;
    drive(32'h0, 0, 0);    chk("lu_issue_valid", int'(a_valid), 1); chk("lu_issue_alu", int'(a_alu), 0);
    chk("lu_issue_rd", int'(a_rd), 6); tick;
    drive(LW0, 1, 0);      tick;
    drive(ADD_X0, 1, 0);   chk("x0_nostall", int'(a_stall), 0);   tick;
    drive(LW5, 1, 0);      tick;
    drive(ADD_IND, 1, 0);  chk("nodep_nostall", int'(a_stall), 0); tick;

    // flush together with a load-use hazard
    drive(LW5, 1, 0);      tick;
    drive(ADD_DEP, 1, 1);  chk("flush_hz_stall", int'(a_stall), 0); tick;
    drive(32'h0, 0, 0);    chk("flush_bubble", int'(a_valid), 0);   tick;

    // 4-cycle divide on A; illegal on B
    drive(DIV, 1, 0);      tick;
    v = 0; h = 0; s = 0;
    for (int k = 0; k < 4; k++) begin
      drive(ADD_IND, 1, 0);
      v += (a_valid && a_alu == 5'd14) ? 1 : 0;
      h += int'(a_hold);
      s += int'(a_stall);
      if (k == 0) begin
        chk("nom_div_illegal", int'(b_ill), 1);
        chk("nom_div_valid", int'(b_valid), 1);
        chk("nom_div_regw", int'(b_regw), 0);
        chk("nom_div_alu", int'(b_alu), 0);
        chk("nom_div_hold", int'(b_hold), 0);
      end
      tick;
    end
    chk("div_ex_cycles", v, 4);
    chk("div_hold_cycles", h, 3);
    chk("div_stall_cycles", s, 3);
    drive(32'h0, 0, 0);    chk("div_release_alu", int'(a_alu), 0); chk("div_release_rd", int'(a_rd), 6); tick;

    drive(BGEU, 1, 0);     tick;
    drive(32'h0, 0, 0);    chk("bgeu_branch", int'(a_dob), 1); chk("bgeu_alu", int'(a_alu), 31);
    chk("bgeu_regw", int'(a_regw), 0); tick;
    drive(32'h7F, 1, 0);   tick;
    drive(32'h0, 0, 0);    chk("opc7f_illegal", int'(a_ill), 1); chk("opc7f_valid", int'(a_valid), 1);
    chk("opc7f_regw", int'(a_regw), 0); tick;

    // asynchronous reset while busy
    drive(DIV, 1, 0);      tick;
    drive(ADD_IND, 1, 0);  chk("busy_before_rst", int'(a_hold), 1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy_bundle", $countones(obs_a), 0);
    chk("rst_busy_hold", int'(a_hold), 0);
    chk("rst_busy_stall", int'(a_stall), 0);
    exp_a = '0; exp_b = '0; hold_a = 0; hold_b = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // randomized traffic; IF/ID is held while A stalls
    keep = 0;
    for (int n = 0; n < 2000; n++) begin
      if (keep) drive(instr, id_valid, (hold_a == 0) && ($urandom_range(0, 15) == 0));
      else      drive(rand_instr(), $urandom_range(0, 7) != 0, (hold_a == 0) && ($urandom_range(0, 9) == 0));
      keep = (hold_a > 0) || (!flush && lu(exp_a, 1'b1));
      tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
